// File: rtl/mips_io_pkg.sv
// Shared definitions for the display-side I/O blocks: scan FSM states,
// the hex-to-segment table and the leading-zero blanking rule.
package mips_io_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

  // All cathodes off (active-low segments).
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} codes for hex digits 0..F.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // A digit above position 0 is suppressed when it and every more
  // significant nibble are zero; the rightmost digit always shows.
  function automatic logic lz_blanked(input logic [15:0] h,
                                      input logic [1:0]  d,
                                      input logic        lz);
    logic z;
    case (d)
      2'd1:    z = (h[15:4]  == 12'h000);
      2'd2:    z = (h[15:8]  == 8'h00);
      2'd3:    z = (h[15:12] == 4'h0);
      default: z = 1'b0;
    endcase
    return lz & z;
  endfunction

endpackage

// File: rtl/hex7seg.sv
// Combinational nibble to active-low seven-segment decoder.
module hex7seg
  import mips_io_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  // Straight table lookup; no state.
  always_comb begin
    seg_o = SEG_TABLE[nibble_i];
  end

endmodule

// File: rtl/sevenseg_scan.sv
// Four-digit common-anode display scanner with dead-time blanking
// between digits and a once-per-frame snapshot of the value shown.
//
// Handshake note: there is no valid/ready pair here; en is a level
// enable sampled on every clock edge, and hex/dp_mask/blank_lz are
// captured only on the cycle that frame_tick is registered high.
module sevenseg_scan
  import mips_io_pkg::*;
#(
  parameter int DIV       = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [15:0] hex,
  input  logic [3:0]  dp_mask,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick,
  output scan_state_t dbg_state_o
);

  localparam int MAXC = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] SHOW_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

  scan_state_t   state_q, state_d;
  logic [1:0]    digit_q, digit_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   snap_hex_q, snap_hex_d;
  logic [3:0]    snap_dp_q, snap_dp_d;
  logic          snap_lz_q, snap_lz_d;
  logic          tick_d;

  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          tick_q;

  logic [6:0]    dec_seg;

  // State, counters and snapshot registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      digit_q    <= 2'd0;
      cnt_q      <= '0;
      snap_hex_q <= 16'h0000;
      snap_dp_q  <= 4'h0;
      snap_lz_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      digit_q    <= digit_d;
      cnt_q      <= cnt_d;
      snap_hex_q <= snap_hex_d;
      snap_dp_q  <= snap_dp_d;
      snap_lz_q  <= snap_lz_d;
    end
  end

  // Next-state logic: dwell counting, digit advance and snapshot capture.
  always_comb begin
    state_d    = state_q;
    digit_d    = digit_q;
    cnt_d      = cnt_q;
    snap_hex_d = snap_hex_q;
    snap_dp_d  = snap_dp_q;
    snap_lz_d  = snap_lz_q;
    tick_d     = 1'b0;
    if (!en) begin
      // Disable leaves digit/cnt/snapshot untouched; IDLE ignores them.
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = BLANK;
          digit_d = 2'd0;
          cnt_d   = '0;
          tick_d  = 1'b1;
        end
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            state_d = BLANK;
            cnt_d   = '0;
            digit_d = digit_q + 2'd1;
            if (digit_q == 2'd3) begin
              tick_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
      if (tick_d) begin
        snap_hex_d = hex;
        snap_dp_d  = dp_mask;
        snap_lz_d  = blank_lz;
      end
    end
  end

  // Decode the nibble the next cycle will show, so outputs can be registered.
  hex7seg u_dec (
    .nibble_i (snap_hex_d[4*digit_d +: 4]),
    .seg_o    (dec_seg)
  );

  // Output logic from next-state values: lit only in SHOW and not suppressed.
  always_comb begin
    an_d  = 4'hF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (state_d == SHOW && !lz_blanked(snap_hex_d, digit_d, snap_lz_d)) begin
      an_d  = ~(4'b0001 << digit_d);
      seg_d = dec_seg;
      dp_d  = ~snap_dp_d[digit_d];
    end
  end

  // Registered display outputs keep the pins glitch-free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_q   <= 4'hF;
      seg_q  <= SEG_OFF;
      dp_q   <= 1'b1;
      tick_q <= 1'b0;
    end else begin
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      tick_q <= tick_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign frame_tick  = tick_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Self-checking bench for sevenseg_scan with DIV=4, BLANK_CYC=2.
// The reference model tracks only "time since the frame started" and
// derives slot/phase arithmetically from the 24-cycle frame.
module tb_sevenseg_scan;
  import mips_io_pkg::*;

  localparam int DIV   = 4;
  localparam int BLANK = 2;
  localparam int SLOT  = DIV + BLANK;
  localparam int FRAME = 4 * SLOT;

  // Clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        en;
  logic [15:0] hex;
  logic [3:0]  dp_mask;
  logic        blank_lz;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;
  scan_state_t dbg_state;

  sevenseg_scan #(.DIV(DIV), .BLANK_CYC(BLANK)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .hex         (hex),
    .dp_mask     (dp_mask),
    .blank_lz    (blank_lz),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .frame_tick  (frame_tick),
    .dbg_state_o (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // Reference segment codes written out independently of the RTL package.
  logic [6:0] seg_ref [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Model state
  bit          m_active;
  int          m_t;
  logic [15:0] m_hex;
  logic [3:0]  m_dp;
  logic        m_lz;
  logic [12:0] exp_q [$];

  localparam logic [12:0] DARK = {4'hF, 7'h7F, 1'b1, 1'b0};

  function automatic logic [12:0] model_out();
    int q, slot, ph;
    logic [3:0] nib;
    bit blanked, tick;
    if (!m_active) return DARK;
    q    = m_t % FRAME;
    slot = q / SLOT;
    ph   = q % SLOT;
    tick = (q == 0);
    nib  = 4'((m_hex >> (4 * slot)) & 16'hF);
    blanked = m_lz && (slot > 0) && ((m_hex >> (4 * slot)) == 0);
    if (ph >= BLANK && !blanked)
      return {4'hF & ~(4'b0001 << slot), seg_ref[nib], ~m_dp[slot], tick};
    return {4'hF, 7'h7F, 1'b1, tick};
  endfunction

  task automatic model_reset();
    m_active = 0;
    m_t      = 0;
    m_hex    = 16'h0000;
    m_dp     = 4'h0;
    m_lz     = 1'b0;
  endtask

  // Advance the model across one clock edge using the inputs now applied.
  task automatic model_edge();
    if (!en) begin
      m_active = 0;
    end else begin
      if (!m_active) begin
        m_active = 1;
        m_t = 0;
      end else begin
        m_t++;
      end
      if (m_t % FRAME == 0) begin
        m_hex = hex;
        m_dp  = dp_mask;
        m_lz  = blank_lz;
      end
    end
  endtask

  // Driver: one clock, model kept in step; outputs sampled 1 ns after the edge.
  task automatic step();
    model_edge();
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b0; hex = 16'h0; dp_mask = 4'h0; blank_lz = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (an !== 4'hF) begin errors++; $display("FAIL reset_an got %h exp F", an); end
    checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg got %h exp 7F", seg); end
    checks++; if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp got %b exp 1", dp); end
    checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b exp 0", frame_tick); end
    reset = 1'b0;
    repeat (2) begin
      step();
      checks++;
      if ({an, seg, dp, frame_tick} !== exp_q.pop_front()) begin
        errors++; $display("FAIL idle_dark got %h", {an, seg, dp, frame_tick});
      end
    end
  endtask

  task automatic test_basic();
    logic [12:0] e;
    hex = 16'h1234; blank_lz = 1'b0; dp_mask = 4'h0; en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if ({an, seg, dp, frame_tick} !== e) begin
        errors++; $display("FAIL basic cyc %0d got %h exp %h", i, {an, seg, dp, frame_tick}, e);
      end
    end
    // Spot check against literal values: t=29 is digit 0 lit in frame 2.
    checks++;
    if ({an, seg} !== {4'hE, 7'h19}) begin
      errors++; $display("FAIL basic_digit0 got %h/%h exp E/19", an, seg);
    end
  endtask

  task automatic test_midframe_change();
    logic [12:0] e;
    bit changed = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (!changed && m_active && ((m_t % FRAME) / SLOT == 1)) begin
        hex = 16'hABCD;
        changed = 1;
      end
      step();
      e = exp_q.pop_front();
      checks++;
      if ({an, seg, dp, frame_tick} !== e) begin
        errors++; $display("FAIL midframe cyc %0d got %h exp %h", i, {an, seg, dp, frame_tick}, e);
      end
    end
  endtask

  task automatic test_pattern(input logic [15:0] h, input logic [3:0] dm, input logic lz);
    logic [12:0] e;
    hex = h; dp_mask = dm; blank_lz = lz;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if ({an, seg, dp, frame_tick} !== e) begin
        errors++; $display("FAIL pattern_%h cyc %0d got %h exp %h", h, i, {an, seg, dp, frame_tick}, e);
      end
    end
  endtask

  task automatic test_en_drop();
    logic [12:0] e;
    bit found = 0;
    hex = 16'h5678; blank_lz = 1'b0; dp_mask = 4'h4;
    for (int i = 0; i < 3 * FRAME && !found; i++) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if ({an, seg, dp, frame_tick} !== e) begin
        errors++; $display("FAIL en_drop_pre got %h exp %h", {an, seg, dp, frame_tick}, e);
      end
      if (m_active && (m_t % FRAME) / SLOT == 2 && (m_t % SLOT) == BLANK + 1) found = 1;
    end
    if (!found) begin
      checks++; errors++; $display("FAIL en_drop_wait got timeout exp digit2 lit");
    end
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if ({an, seg, dp, frame_tick} !== e) begin
        errors++; $display("FAIL en_drop_dark cyc %0d got %h exp %h", i, {an, seg, dp, frame_tick}, e);
      end
    end
    en = 1'b1;
    for (int i = 0; i < FRAME + 4; i++) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if ({an, seg, dp, frame_tick} !== e) begin
        errors++; $display("FAIL reenable cyc %0d got %h exp %h", i, {an, seg, dp, frame_tick}, e);
      end
    end
  endtask

  task automatic test_random();
    logic [12:0] e;
    for (int i = 0; i < 400; i++) begin
      hex      = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      dp_mask  = 4'($urandom_range(0, 15));
      blank_lz = 1'($urandom_range(0, 1));
      en       = ($urandom_range(0, 39) != 0);
      step();
      e = exp_q.pop_front();
      checks++;
      if ({an, seg, dp, frame_tick} !== e) begin
        errors++; $display("FAIL random cyc %0d got %h exp %h", i, {an, seg, dp, frame_tick}, e);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [12:0] e;
    bit found = 0;
    en = 1'b1; hex = 16'h9E3F; dp_mask = 4'hF; blank_lz = 1'b0;
    for (int i = 0; i < 3 * FRAME && !found; i++) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if ({an, seg, dp, frame_tick} !== e) begin
        errors++; $display("FAIL areset_pre got %h exp %h", {an, seg, dp, frame_tick}, e);
      end
      if (an != 4'hF) found = 1;
    end
    if (!found) begin
      checks++; errors++; $display("FAIL areset_wait got timeout exp lit digit");
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
      errors++; $display("FAIL areset_async got %h/%h/%b exp F/7F/1", an, seg, dp);
    end
    model_reset();
    en = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if ({an, seg, dp, frame_tick} !== e) begin
        errors++; $display("FAIL areset_dark cyc %0d got %h exp %h", i, {an, seg, dp, frame_tick}, e);
      end
    end
    en = 1'b1;
    for (int i = 0; i < FRAME + 2; i++) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if ({an, seg, dp, frame_tick} !== e) begin
        errors++; $display("FAIL areset_resume cyc %0d got %h exp %h", i, {an, seg, dp, frame_tick}, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_midframe_change();
    test_pattern(16'h0050, 4'h0, 1'b1);
    test_pattern(16'h0000, 4'b0001, 1'b1);
    test_en_drop();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout got no finish exp finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sevenseg_scan.md
# sevenseg_scan

Drives the board's four-digit, common-anode seven-segment display from the 16-bit `hex` register produced by the memory-mapped I/O block. It time-multiplexes one digit at a time and inserts a dead-time blank between digits to suppress ghosting. It snapshots `hex` once per scan frame so a digit never shows a half-updated value. Sits between the MMIO block's `hex` output and the top-level display pins.

## Interface
- `DIV`, default 50000: cycles each digit is lit; must be ≥ 1.
- `BLANK_CYC`, default 500: dead-time cycles with all anodes off before each digit; must be ≥ 1.
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `en`  in  1  display enable; 0 = all digits dark.
- `hex`  in  16  value to show; nibble i drives digit i, with digit 0 rightmost.
- `dp_mask`  in  4  bit i = 1 lights the decimal point of digit i; sampled with `hex`.
- `blank_lz`  in  1  leading-zero blanking enable; sampled with `hex`.
- `an`  out  4  anode enables, active-low; one-hot-low or all 1.
- `seg`  out  7  cathodes `{g,f,e,d,c,b,a}`, active-low.
- `dp`  out  1  decimal-point cathode, active-low.
- `frame_tick`  out  1  one-cycle pulse when a new snapshot is taken.

## Operation
- The FSM has three states: IDLE, BLANK and SHOW.
- Registers:
  - state;
  - 2-bit `digit`;
  - counter `cnt`, width `$clog2(max(DIV,BLANK_CYC))`, minimum 1;
  - snapshot `snap_hex[15:0]`, `snap_dp[3:0]` and `snap_lz`.
- IDLE: outputs dark. If `en`=1, go to BLANK with `digit`=0 and `cnt`=0, take a snapshot, and pulse `frame_tick`.
- BLANK: outputs dark. `cnt` counts 0..BLANK_CYC-1; at BLANK_CYC-1, go to SHOW with `cnt`=0.
- SHOW: `an[digit]`=0 and the other anodes 1; `seg` = decode(`snap_hex[4*digit+:4]`); `dp` = ~`snap_dp[digit]`.
  - `cnt` counts 0..DIV-1. At DIV-1, go to BLANK with `cnt`=0 and `digit`+1, wrapping mod 4.
  - On the 3→0 wrap, take a new snapshot and pulse `frame_tick` on the same cycle.
- `en`=0 in any state: go to IDLE next edge. `digit`, `cnt` and the snapshot are left unchanged but unused.
- Leading-zero blanking, when `snap_lz`=1:
  - Digit k (k = 3..1) is blanked if its nibble and every higher nibble are 0.
  - A blanked digit keeps its time slot, but `an` stays all 1 and `seg`/`dp` stay all 1.
  - Digit 0 is never blanked.
- Decode is standard hex, 0–F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (7-bit hex, active-low).

## Timing
- Reset (async assert, sync release): state IDLE, `digit`=0, `cnt`=0, snapshot 0; `an`=4'hF, `seg`=7'h7F, `dp`=1, `frame_tick`=0.
- `an`, `seg`, `dp` and `frame_tick` are registered and loaded from next-state values. They are valid in the same cycle the FSM occupies the corresponding state, and are glitch-free.
- Latency: `en` rising at edge N puts the FSM in BLANK at N+1. Digit 0 lights at N+1+BLANK_CYC.
- Frame period is 4·(BLANK_CYC+DIV) cycles. A `hex` change is visible no later than one frame plus BLANK_CYC+DIV cycles after it is written.
- `hex`, `dp_mask` and `blank_lz` are sampled only on snapshot cycles. Mid-frame changes have no effect until the next wrap.
- Reset asserted mid-SHOW forces `an` dark immediately and asynchronously. No partial digit resumes after release.
- `en` deasserted in SHOW: display goes dark on the next edge. Re-enable restarts at digit 0 with a fresh snapshot.

## Structure
- Shared package `mips_io_pkg` holds:
  - the `scan_state_t` enum (IDLE/BLANK/SHOW);
  - the 16-entry segment-code localparam array;
  - the `SEG_OFF` = 7'h7F constant.
- One sub-module, `hex7seg`: purely combinational, 4-bit nibble → 7-bit active-low segments, table from the package.

## Test plan
All scenarios use DIV=4 and BLANK_CYC=2, giving a 24-cycle frame.
- Reset, then `en`=1 with `hex`=16'h1234 and `blank_lz`=0 → `frame_tick` pulses once. After 2 dark cycles, each digit is lit for 4 cycles in sequence:
  - digit 0: `an`=4'hE, `seg`=7'h19;
  - digit 1: `an`=4'hD, `seg`=7'h30;
  - digit 2: `an`=4'hB, `seg`=7'h24;
  - digit 3: `an`=4'h7, `seg`=7'h79.
- `hex` changed to 16'hABCD during digit 1 → the current frame still shows 1234. The next frame shows `seg` 21, 46, 03, 08, and `frame_tick` recurs every 24 cycles.
- `hex`=16'h0050 with `blank_lz`=1 → digits 3 and 2 keep `an`=4'hF during their slots. Digit 1 shows 7'h12 and digit 0 shows 7'h40.
- `hex`=0 with `blank_lz`=1 and `dp_mask`=4'b0001 → only digit 0 lights, with `seg`=7'h40 and `dp`=0.
- `en` dropped mid-SHOW of digit 2 → `an`=4'hF on the next edge. Re-enable restarts at digit 0 after 2 blank cycles.
- `reset` pulsed asynchronously mid-SHOW → `an`, `seg` and `dp` go to F/7F/1 without waiting for a clock edge. After release, output stays dark until `en` is seen.
